// File: rtl/trigger_sequencer_if.sv
// Register bus shared by the trigger blocks.
// A host drives a command code, a byte index within that command and read/write strobes.
// The selected block returns read data combinationally.
//   reg_cmd       : command code being executed
//   reg_bytecount : byte index within the command
//   reg_data_in   : write data
//   reg_data_out  : read data (block -> host)
//   reg_read      : read strobe
//   reg_write     : write strobe
interface trigger_sequencer_if;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;

  modport master (
    output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
    input  reg_data_out
  );

  modport slave (
    input  reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
    output reg_data_out
  );
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: arms on a host command and waits for a trigger pulse from the edge detector.
// After the trigger it waits a programmable delay, then emits a train of count pulses.
// Each pulse is width cycles high, and consecutive pulses are separated by gap cycles low.
// Optional macro TRIGGER_SEQ_TIMEOUT_EN: leaving ARMED after TIMEOUT_CYCLES without a trigger
// drops back to IDLE and sets the timeout flag (CTRL bit3).
// Ports:
//   clk_usb    : single clock for registers and sequencing
//   reset      : asynchronous active-high reset
//   reg_bus    : register bus (slave side), read data is combinational
//   trigger_in : trigger pulse, already synchronous to clk_usb
//   pulse_out  : registered output pulse train
//   busy       : high in DELAY, PULSE or GAP
//   armed      : high in ARMED
module trigger_sequencer #(
  parameter logic [7:0]  CMD_CTRL       = 8'h20,
  parameter logic [7:0]  CMD_DELAY      = 8'h21,
  parameter logic [7:0]  CMD_WIDTH      = 8'h22,
  parameter logic [7:0]  CMD_GAP        = 8'h23,
  parameter logic [7:0]  CMD_COUNT      = 8'h24,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                      clk_usb,
  input  logic                      reset,
  trigger_sequencer_if.slave        reg_bus,
  input  logic                      trigger_in,
  output logic                      pulse_out,
  output logic                      busy,
  output logic                      armed
);

  typedef enum logic [2:0] {StIdle, StArmed, StDelay, StPulse, StGap} state_e;

  state_e      r_state;
  logic [23:0] r_delay;
  logic [15:0] r_width;
  logic [15:0] r_gap;
  logic [7:0]  r_count;
  logic        r_auto_rearm;
  logic        r_done;
  logic        r_pulse_out;
  logic [23:0] r_cnt;
  logic [7:0]  r_pulses_left;
  logic        w_timeout;

  logic        w_wr_ctrl;
  logic        w_arm;
  logic        w_abort;
  logic [23:0] w_width_m1;
  logic [23:0] w_gap_m1;
  logic [7:0]  w_count_eff;
  logic [7:0]  w_rd_data;

  assign w_wr_ctrl = reg_bus.reg_write && (reg_bus.reg_cmd == CMD_CTRL);
  assign w_arm     = w_wr_ctrl && reg_bus.reg_data_in[0];
  assign w_abort   = w_wr_ctrl && reg_bus.reg_data_in[1];

  // Width 0 and count 0 behave as 1; gap-1 is only used when gap is non-zero.
  assign w_width_m1  = (r_width == 16'd0) ? 24'd0 : {8'd0, r_width - 16'd1};
  assign w_gap_m1    = {8'd0, r_gap - 16'd1};
  assign w_count_eff = (r_count == 8'd0) ? 8'd1 : r_count;

  assign pulse_out = r_pulse_out;
  assign busy      = (r_state == StDelay) || (r_state == StPulse) || (r_state == StGap);
  assign armed     = (r_state == StArmed);

`ifdef TRIGGER_SEQ_TIMEOUT_EN
  logic        r_timeout;
  logic [23:0] r_to_cnt;
  assign w_timeout = r_timeout;
`else
  logic w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Configuration registers, byte-addressed little-endian.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      r_delay      <= 24'd0;
      r_width      <= 16'd1;
      r_gap        <= 16'd1;
      r_count      <= 8'd1;
      r_auto_rearm <= 1'b0;
    end else if (reg_bus.reg_write) begin
      case (reg_bus.reg_cmd)
        CMD_CTRL: r_auto_rearm <= reg_bus.reg_data_in[2];
        CMD_DELAY: begin
          case (reg_bus.reg_bytecount)
            16'd0:   r_delay[7:0]   <= reg_bus.reg_data_in;
            16'd1:   r_delay[15:8]  <= reg_bus.reg_data_in;
            16'd2:   r_delay[23:16] <= reg_bus.reg_data_in;
            default: ;
          endcase
        end
        CMD_WIDTH: begin
          case (reg_bus.reg_bytecount)
            16'd0:   r_width[7:0]  <= reg_bus.reg_data_in;
            16'd1:   r_width[15:8] <= reg_bus.reg_data_in;
            default: ;
          endcase
        end
        CMD_GAP: begin
          case (reg_bus.reg_bytecount)
            16'd0:   r_gap[7:0]  <= reg_bus.reg_data_in;
            16'd1:   r_gap[15:8] <= reg_bus.reg_data_in;
            default: ;
          endcase
        end
        CMD_COUNT: begin
          if (reg_bus.reg_bytecount == 16'd0) r_count <= reg_bus.reg_data_in;
        end
        default: ;
      endcase
    end
  end

  // Sequencer. pulse_out follows the PULSE state one cycle later, except that abort clears it
  // on the same edge that returns the state to IDLE.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_done        <= 1'b0;
      r_pulse_out   <= 1'b0;
      r_cnt         <= 24'd0;
      r_pulses_left <= 8'd0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      r_timeout     <= 1'b0;
      r_to_cnt      <= 24'd0;
`endif
    end else begin
      r_pulse_out <= (r_state == StPulse) && !w_abort;
      if (w_wr_ctrl) begin
        r_done <= 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        r_timeout <= 1'b0;
`endif
      end
      if (w_abort) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_arm) begin
              r_state <= StArmed;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
              r_to_cnt <= 24'd0;
`endif
            end
          end
          StArmed: begin
            if (trigger_in) begin
              r_pulses_left <= w_count_eff;
              if (r_delay == 24'd0) begin
                r_state <= StPulse;
                r_cnt   <= w_width_m1;
              end else begin
                r_state <= StDelay;
                r_cnt   <= r_delay - 24'd1;
              end
            end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
            else if (r_to_cnt >= TIMEOUT_CYCLES - 24'd1) begin
              r_state   <= StIdle;
              r_timeout <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 24'd1;
            end
`endif
          end
          StDelay: begin
            if (r_cnt == 24'd0) begin
              r_state <= StPulse;
              r_cnt   <= w_width_m1;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          StPulse: begin
            if (r_cnt != 24'd0) begin
              r_cnt <= r_cnt - 24'd1;
            end else if (r_pulses_left > 8'd1) begin
              r_pulses_left <= r_pulses_left - 8'd1;
              // Zero gap re-enters PULSE directly so the pulses merge.
              if (r_gap == 16'd0) begin
                r_cnt <= w_width_m1;
              end else begin
                r_state <= StGap;
                r_cnt   <= w_gap_m1;
              end
            end else begin
              r_pulses_left <= 8'd0;
              r_done        <= 1'b1;
              r_state       <= r_auto_rearm ? StArmed : StIdle;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
              r_to_cnt <= 24'd0;
`endif
            end
          end
          StGap: begin
            if (r_cnt == 24'd0) begin
              r_state <= StPulse;
              r_cnt   <= w_width_m1;
            end else begin
              r_cnt <= r_cnt - 24'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Combinational read-back; out-of-range bytes and unknown commands read zero.
  always_comb begin
    w_rd_data = 8'h00;
    if (reg_bus.reg_read) begin
      case (reg_bus.reg_cmd)
        CMD_CTRL: w_rd_data = {4'b0000, w_timeout, r_auto_rearm, r_done, busy | armed};
        CMD_DELAY: begin
          case (reg_bus.reg_bytecount)
            16'd0:   w_rd_data = r_delay[7:0];
            16'd1:   w_rd_data = r_delay[15:8];
            16'd2:   w_rd_data = r_delay[23:16];
            default: w_rd_data = 8'h00;
          endcase
        end
        CMD_WIDTH: begin
          case (reg_bus.reg_bytecount)
            16'd0:   w_rd_data = r_width[7:0];
            16'd1:   w_rd_data = r_width[15:8];
            default: w_rd_data = 8'h00;
          endcase
        end
        CMD_GAP: begin
          case (reg_bus.reg_bytecount)
            16'd0:   w_rd_data = r_gap[7:0];
            16'd1:   w_rd_data = r_gap[15:8];
            default: w_rd_data = 8'h00;
          endcase
        end
        CMD_COUNT: w_rd_data = (reg_bus.reg_bytecount == 16'd0) ? r_count : 8'h00;
        default:   w_rd_data = 8'h00;
      endcase
    end
  end

  assign reg_bus.reg_data_out = w_rd_data;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer.
// The reference model expands each accepted trigger into a queue of per-cycle phases:
// delay cycles, then width cycles per pulse with gap cycles between pulses.
// The bench then checks pulse_out, busy, armed and the read data on every clock.
// Directed sections pin the model with hand-computed waveforms.
module tb_trigger_sequencer;
  localparam logic [7:0] C_CTRL  = 8'h20;
  localparam logic [7:0] C_DELAY = 8'h21;
  localparam logic [7:0] C_WIDTH = 8'h22;
  localparam logic [7:0] C_GAP   = 8'h23;
  localparam logic [7:0] C_COUNT = 8'h24;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 0;
`endif
  // Model phases: idle, armed, delay, pulse, gap, end-of-train marker.
  localparam int SI = 0, SA = 1, SD = 2, SP = 3, SG = 4, SE = 5;

  logic clk_usb = 1'b0;
  logic reset = 1'b1;
  logic trigger_in = 1'b0;
  logic pulse_out, busy, armed;

  trigger_sequencer_if bus();

  trigger_sequencer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk_usb   (clk_usb),
    .reset     (reset),
    .reg_bus   (bus),
    .trigger_in(trigger_in),
    .pulse_out (pulse_out),
    .busy      (busy),
    .armed     (armed)
  );

  always #5 clk_usb = ~clk_usb;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;

  int          m_cur;
  int          sched[$];
  logic [23:0] m_delay;
  logic [15:0] m_width, m_gap;
  logic [7:0]  m_count;
  bit          m_auto, m_done, m_to, m_pulse;
  int          m_arm_at;

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = SI; sched.delete();
    m_delay = 24'd0; m_width = 16'd1; m_gap = 16'd1; m_count = 8'd1;
    m_auto = 0; m_done = 0; m_to = 0; m_pulse = 0; m_arm_at = cyc;
  endtask

  task automatic build_train();
    int n, w;
    n = (m_count == 8'd0) ? 1 : int'(m_count);
    w = (m_width == 16'd0) ? 1 : int'(m_width);
    repeat (int'(m_delay)) sched.push_back(SD);
    for (int k = 0; k < n; k++) begin
      repeat (w) sched.push_back(SP);
      if (k < n - 1) repeat (int'(m_gap)) sched.push_back(SG);
    end
    sched.push_back(SE);
  endtask

  task automatic advance();
    int nxt;
    if (sched.size() == 0) begin
      m_cur = SI;
    end else begin
      nxt = sched.pop_front();
      if (nxt == SE) begin
        m_done = 1;
        if (m_auto) begin m_cur = SA; m_arm_at = cyc; end
        else m_cur = SI;
      end else begin
        m_cur = nxt;
      end
    end
  endtask

  task automatic model_edge(input logic trig, input logic wr, input logic [7:0] cmd,
                            input logic [15:0] bc, input logic [7:0] d);
    int  prev, b;
    bit  is_ctrl, abort, arm;
    prev    = m_cur;
    is_ctrl = wr && (cmd == C_CTRL);
    abort   = is_ctrl && d[1];
    arm     = is_ctrl && d[0];
    m_pulse = (prev == SP) && !abort;
    if (is_ctrl) begin m_done = 0; m_to = 0; end
    if (abort) begin
      m_cur = SI; sched.delete();
    end else if (prev == SI) begin
      if (arm) begin m_cur = SA; m_arm_at = cyc; end
    end else if (prev == SA) begin
      if (trig) begin
        build_train();
        advance();
      end else if (TO_CYC != 0 && (cyc - m_arm_at) >= TO_CYC) begin
        m_cur = SI; m_to = 1;
      end
    end else begin
      advance();
    end
    // Register writes land after the sequencer used the old values.
    if (wr) begin
      b = int'(bc);
      case (cmd)
        C_CTRL:  m_auto = d[2];
        C_DELAY: if (b < 3) m_delay[8*b +: 8] = d;
        C_WIDTH: if (b < 2) m_width[8*b +: 8] = d;
        C_GAP:   if (b < 2) m_gap[8*b +: 8] = d;
        C_COUNT: if (b == 0) m_count = d;
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic rd, input logic [7:0] cmd,
                                        input logic [15:0] bc);
    logic [31:0] v;
    int nb, b;
    if (!rd) return 8'h00;
    b = int'(bc);
    case (cmd)
      C_CTRL:  return {4'b0000, m_to, m_auto, m_done, (m_cur != SI)};
      C_DELAY: begin v = {8'h00, m_delay}; nb = 3; end
      C_WIDTH: begin v = {16'h0000, m_width}; nb = 2; end
      C_GAP:   begin v = {16'h0000, m_gap}; nb = 2; end
      C_COUNT: begin v = {24'h0, m_count}; nb = 1; end
      default: return 8'h00;
    endcase
    if (b >= nb) return 8'h00;
    return v[8*b +: 8];
  endfunction

  // Model update on each edge, then compare just after it.
  initial begin
    logic s_rst, s_trig, s_wr;
    logic [7:0] s_cmd, s_d;
    logic [15:0] s_bc;
    forever begin
      @(posedge clk_usb);
      s_rst = reset; s_trig = trigger_in; s_wr = bus.reg_write;
      s_cmd = bus.reg_cmd; s_bc = bus.reg_bytecount; s_d = bus.reg_data_in;
      cyc++;
      if (s_rst) model_reset();
      else model_edge(s_trig, s_wr, s_cmd, s_bc, s_d);
      #1;
      check1("pulse_out", pulse_out, m_pulse);
      check1("busy", busy, (m_cur == SD) || (m_cur == SP) || (m_cur == SG));
      check1("armed", armed, m_cur == SA);
      check8("reg_data_out", bus.reg_data_out,
             exp_rd(bus.reg_read, bus.reg_cmd, bus.reg_bytecount));
    end
  end

  task automatic idle(input int n);
    @(negedge clk_usb);
    bus.reg_read = 0; bus.reg_write = 0; trigger_in = 0;
    repeat (n - 1) @(negedge clk_usb);
  endtask

  task automatic wr(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] d);
    @(negedge clk_usb);
    bus.reg_read = 0; bus.reg_write = 1;
    bus.reg_cmd = cmd; bus.reg_bytecount = bc; bus.reg_data_in = d;
    @(negedge clk_usb);
    bus.reg_write = 0;
  endtask

  task automatic rd_set(input logic [7:0] cmd, input logic [15:0] bc);
    @(negedge clk_usb);
    bus.reg_write = 0; bus.reg_read = 1; bus.reg_cmd = cmd; bus.reg_bytecount = bc;
  endtask

  task automatic rd_check(input string name, input logic [7:0] cmd, input logic [15:0] bc,
                          input logic [7:0] exp);
    rd_set(cmd, bc);
    #1;
    check8(name, bus.reg_data_out, exp);
  endtask

  task automatic trig();
    @(negedge clk_usb);
    bus.reg_read = 0; bus.reg_write = 0; trigger_in = 1;
    @(negedge clk_usb);
    trigger_in = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_usb);
    bus.reg_read = 0; bus.reg_write = 0; trigger_in = 0; reset = 1;
    @(negedge clk_usb);
    reset = 0;
  endtask

  initial begin
    logic [10:1] pat2;
    logic [15:1] pat3;
    logic [7:0] d;
    int op;
    bus.reg_cmd = 8'h00; bus.reg_bytecount = 16'h0; bus.reg_data_in = 8'h00;
    bus.reg_read = 0; bus.reg_write = 0;
    repeat (3) @(negedge clk_usb);
    reset = 0;

    // Reset defaults.
    rd_check("rst_ctrl", C_CTRL, 16'd0, 8'h00);
    rd_check("rst_width0", C_WIDTH, 16'd0, 8'h01);
    rd_check("rst_width1", C_WIDTH, 16'd1, 8'h00);
    rd_check("rst_gap0", C_GAP, 16'd0, 8'h01);
    rd_check("rst_count", C_COUNT, 16'd0, 8'h01);
    rd_check("rst_delay0", C_DELAY, 16'd0, 8'h00);
    rd_check("rst_width_oob", C_WIDTH, 16'd2, 8'h00);
    rd_check("unknown_cmd", 8'h30, 16'd0, 8'h00);

    // delay=5, width=3: pulse_out high on edges t+6..t+8.
    wr(C_DELAY, 16'd0, 8'd5); wr(C_DELAY, 16'd1, 8'd0); wr(C_DELAY, 16'd2, 8'd0);
    wr(C_WIDTH, 16'd0, 8'd3); wr(C_COUNT, 16'd0, 8'd1);
    wr(C_WIDTH, 16'd2, 8'hFF);
    rd_check("width_oob_write", C_WIDTH, 16'd0, 8'h03);
    wr(C_CTRL, 16'd0, 8'h01);
    check1("t2_armed", armed, 1'b1);
    trig();
    pat2 = 10'b0011100000;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_usb); #1;
      check1($sformatf("t2_pulse_k%0d", k), pulse_out, pat2[k]);
    end
    idle(2);
    check1("t2_armed_after", armed, 1'b0);
    rd_check("t2_ctrl_done", C_CTRL, 16'd0, 8'h02);

    // delay=0, width=2, gap=4, count=3: 11 0000 11 0000 11 from t+1.
    wr(C_DELAY, 16'd0, 8'd0); wr(C_WIDTH, 16'd0, 8'd2);
    wr(C_GAP, 16'd0, 8'd4); wr(C_COUNT, 16'd0, 8'd3);
    wr(C_CTRL, 16'd0, 8'h01);
    trig();
    pat3 = 15'b011000011000011;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk_usb); #1;
      check1($sformatf("t3_pulse_k%0d", k), pulse_out, pat3[k]);
      if (k == 1 || k == 13) check1($sformatf("t3_busy_k%0d", k), busy, 1'b1);
      if (k == 15) check1("t3_busy_end", busy, 1'b0);
    end

    // Abort during a long pulse; later triggers are ignored.
    wr(C_WIDTH, 16'd0, 8'd100); wr(C_COUNT, 16'd0, 8'd1);
    wr(C_CTRL, 16'd0, 8'h01);
    trig();
    idle(5);
    check1("t4_pulse_before", pulse_out, 1'b1);
    wr(C_CTRL, 16'd0, 8'h03);
    check1("t4_pulse_abort", pulse_out, 1'b0);
    check1("t4_busy_abort", busy, 1'b0);
    check1("t4_armed_abort", armed, 1'b0);
    rd_check("t4_ctrl", C_CTRL, 16'd0, 8'h00);
    trig();
    idle(3);
    check1("t4_trig_ignored", busy, 1'b0);

    // Auto re-arm: two triggers, re-armed after each.
    wr(C_WIDTH, 16'd0, 8'd4);
    wr(C_CTRL, 16'd0, 8'h05);
    trig();
    idle(50);
    check1("t5_rearm1", armed, 1'b1);
    rd_check("t5_ctrl", C_CTRL, 16'd0, 8'h07);
    trig();
    idle(50);
    check1("t5_rearm2", armed, 1'b1);
    wr(C_CTRL, 16'd0, 8'h02);

`ifdef TRIGGER_SEQ_TIMEOUT_EN
    wr(C_CTRL, 16'd0, 8'h01);
    idle(98);
    check1("to_armed_before", armed, 1'b1);
    idle(2);
    check1("to_armed_after", armed, 1'b0);
    rd_check("to_ctrl", C_CTRL, 16'd0, 8'h08);
`endif

    // Asynchronous reset mid-sequence restores everything.
    wr(C_WIDTH, 16'd0, 8'd20); wr(C_CTRL, 16'd0, 8'h01);
    trig();
    idle(3);
    @(negedge clk_usb);
    reset = 1;
    #1;
    check1("rst_async_pulse", pulse_out, 1'b0);
    check1("rst_async_busy", busy, 1'b0);
    @(negedge clk_usb);
    reset = 0;
    rd_check("rst_width_restored", C_WIDTH, 16'd0, 8'h01);

    // Random traffic against the model.
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 99));
      if (op < 20) begin
        trig();
      end else if (op < 40) begin
        d = 8'($urandom);
        d[1] = ($urandom_range(0, 9) == 0);
        d[0] = ($urandom_range(0, 2) != 0);
        wr(C_CTRL, 16'd0, d);
      end else if (op < 60 && (m_cur == SI || m_cur == SA)) begin
        logic [7:0] c;
        logic [15:0] b;
        c = ($urandom_range(0, 9) == 0) ? 8'h30 : 8'(8'h21 + $urandom_range(0, 3));
        b = 16'($urandom_range(0, 3));
        if (b == 16'd0) d = 8'($urandom_range(0, 6));
        else d = ($urandom_range(0, 15) == 0) ? 8'd1 : 8'd0;
        wr(c, b, d);
      end else if (op < 80) begin
        rd_set(8'(8'h1F + $urandom_range(0, 6)), 16'($urandom_range(0, 3)));
      end else if (op == 99) begin
        do_reset();
      end else begin
        idle(int'($urandom_range(1, 6)));
      end
    end
    idle(400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Arms on a host command and waits for a registered trigger pulse from the edge-detector stage.
- After the trigger, it waits a programmable delay, then emits a programmable train of output pulses (width, gap, count) to drive the glitch/trigger output.
- Configured and polled over the shared serial register bus, the same reg_cmd/reg_bytecount/reg_data bus used by the other trigger blocks.
- Acts as the scheduler sitting between the edge detector and the output driver.

Parameters:
- CMD_CTRL, 8'h20, command code for the control/status byte.
- CMD_DELAY, 8'h21, command code for the 24-bit delay register (3 bytes, little-endian).
- CMD_WIDTH, 8'h22, command code for the 16-bit pulse width register (2 bytes, little-endian).
- CMD_GAP, 8'h23, command code for the 16-bit inter-pulse gap register (2 bytes, little-endian).
- CMD_COUNT, 8'h24, command code for the 8-bit pulse count register.
- TIMEOUT_CYCLES, 24'd10_000_000, armed timeout length; used only with the optional feature.

Ports:
- clk_usb  input  1  single clock for registers and sequencing.
- reset  input  1  asynchronous, active-high reset.
- reg_cmd  input  8  command being executed.
- reg_bytecount  input  16  byte index within the command.
- reg_data_in  input  8  write data.
- reg_data_out  output  8  read data, combinational.
- reg_read  input  1  read strobe.
- reg_write  input  1  write strobe.
- trigger_in  input  1  trigger pulse from the edge detector, already synchronous to clk_usb.
- pulse_out  output  1  registered output pulse train.
- busy  output  1  high in DELAY, PULSE or GAP.
- armed  output  1  high in ARMED.

Behaviour:
- Reset values: pulse_out=0, busy=0, armed=0, state=IDLE, done=0, timeout=0. Register defaults: delay=0, width=1, gap=1, count=1, auto_rearm=0.
- CTRL write bits:
  - bit0 arm: self-clearing; accepted only in IDLE.
  - bit1 abort: self-clearing; from any state returns to IDLE and forces pulse_out=0 on the next edge. Abort wins over arm in the same write.
  - bit2 auto_rearm: stored.
  - Writing CTRL clears done.
- CTRL read: {4'b0, timeout, auto_rearm, done, busy|armed}.
- Multi-byte registers are written at byte reg_bytecount. A bytecount beyond the register width is ignored on write and reads 8'h00. An unknown command reads 8'h00. reg_data_out=0 whenever reg_read=0.
- Writes to DELAY/WIDTH/GAP/COUNT are allowed in any state. A new value takes effect at the next counter load only.
- Zero handling: width=0 and count=0 are treated as 1. gap=0 means consecutive pulses merge into a continuous high.
- States and transitions:
  - IDLE: arm accepted → ARMED on the next edge.
  - ARMED: trigger_in=1 at edge t → DELAY with counter=delay-1. If delay=0, go directly to PULSE instead. trigger_in in any other state is ignored.
  - DELAY: counter decrements each cycle; at 0 → PULSE. pulse_out rises at edge t+1+delay.
  - PULSE: pulse_out=1 for exactly width cycles; pulses_left decrements on exit.
    - If pulses remain: → GAP (or straight back to PULSE if gap=0).
    - If none remain: → IDLE with done=1, or → ARMED if auto_rearm=1.
  - GAP: pulse_out=0 for gap cycles, then → PULSE.
- All counters saturate at terminal values and do not wrap. Counters are loaded on state entry.
- reset asserted mid-sequence: immediate async return to reset values, including all registers.

Optional Feature:
- Macro: TRIGGER_SEQ_TIMEOUT_EN.
- With it defined:
  - A 24-bit counter runs while in ARMED.
  - On reaching TIMEOUT_CYCLES with no trigger: → IDLE and timeout flag (CTRL bit3) set.
  - The timeout flag clears on a CTRL write or on a new arm.
  - The counter resets on each ARMED entry.
- Without it: ARMED waits indefinitely; CTRL bit3 reads 0 and no counter logic exists.

Test Plan:
- Reset, then read all registers → CTRL=8'h00, WIDTH=16'h0001, GAP=16'h0001, COUNT=8'h01, DELAY=0.
- delay=5, width=3, count=1, arm, trigger_in pulse at edge t → pulse_out high edges t+6..t+8; done=1 and armed=0 afterwards.
- delay=0, width=2, gap=4, count=3, trigger → pulse_out pattern 11 0000 11 0000 11 starting at t+1; busy high throughout, low after the last pulse.
- Arm, then write abort during PULSE (width=100) → pulse_out=0 next edge, state IDLE; trigger_in is then ignored.
- auto_rearm=1, count=1, two triggers 50 cycles apart with width=4 → two pulses; armed re-asserts after each; done set.
- With TRIGGER_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, arm with no trigger → armed drops after 100 cycles; CTRL read=8'h08.
